repeater_bank: RTL and testbench

REPEATER_BANK -- requirements
Module: repeater_bank

---
 rtl/repeater_bank.sv | 171 +++++++++++++++++
 tb/tb_repeater_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/repeater_bank.sv
// -----------------------------------------------------------------------------
// repeater_bank
//
// Bank of CH independent redstone-style repeaters. Each channel delays a
// change on its input by D = i_delay field + 1 redstone ticks. State only
// moves on clock edges where i_tick is high. A locked channel is frozen.
//
// Optional feature macro: REPEATER_BANK_PULSE_EXT_EN
//   defined   : a rising transition ignores the input, so every input pulse
//               is stretched to at least D ticks on the output.
//   undefined : an input drop while rising cancels the transition, so
//               pulses shorter than D ticks are swallowed.
//
// Parameters
//   CH   number of channels (1..32)
//   DW   delay field width per channel
//   INIT per-channel output value loaded by reset
//
// Ports
//   i_clk      system clock
//   i_rst      synchronous active-high reset (wins over i_tick and i_lock)
//   i_tick     redstone tick strobe
//   i_in       per-channel input power
//   i_lock     per-channel lock, freezes the channel on a tick
//   i_delay    per-channel delay field, channel c at [c*DW +: DW]
//   o_out      per-channel registered output
//   o_pending  per-channel registered flag, high while a transition is timed
// -----------------------------------------------------------------------------
module repeater_bank #(
  parameter int              CH   = 4,
  parameter int              DW   = 2,
  parameter logic [CH-1:0]   INIT = {CH{1'b0}}
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic [CH-1:0]      i_in,
  input  logic [CH-1:0]      i_lock,
  input  logic [CH*DW-1:0]   i_delay,
  output logic [CH-1:0]      o_out,
  output logic [CH-1:0]      o_pending
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RISING  = 2'd1,
    ST_ON      = 2'd2,
    ST_FALLING = 2'd3
  } state_t;

  localparam logic [DW-1:0] CNT_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    state_t          state_r;
    state_t          state_s;
    logic [DW-1:0]   cnt_r;
    logic [DW-1:0]   cnt_s;
    logic [DW-1:0]   field_s;
    logic            advance_s;
    logic            out_r;
    logic            pending_r;

    // The field is only consumed when a transition is launched; the
    // counter then runs on its own, so mid-count edits have no effect.
    assign field_s   = i_delay[c*DW +: DW];
    assign advance_s = i_tick & ~i_lock[c];

    // Next-state and counter logic for one channel.
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      if (advance_s) begin
        case (state_r)
          ST_OFF: begin
            if (i_in[c]) begin
              // A zero field means D=1: switch on the same tick.
              if (field_s == CNT_ZERO) begin
                state_s = ST_ON;
                cnt_s   = CNT_ZERO;
              end else begin
                state_s = ST_RISING;
                cnt_s   = field_s;
              end
            end else begin
              state_s = ST_OFF;
              cnt_s   = cnt_r;
            end
          end
          ST_RISING: begin
`ifdef REPEATER_BANK_PULSE_EXT_EN
            if (cnt_r == CNT_ONE) begin
              state_s = ST_ON;
              cnt_s   = CNT_ZERO;
            end else begin
              state_s = ST_RISING;
              cnt_s   = cnt_r - CNT_ONE;
            end
`else
            // Input dropped before the output rose: swallow the pulse.
            if (!i_in[c]) begin
              state_s = ST_OFF;
              cnt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_ONE) begin
              state_s = ST_ON;
              cnt_s   = CNT_ZERO;
            end else begin
              state_s = ST_RISING;
              cnt_s   = cnt_r - CNT_ONE;
            end
`endif
          end
          ST_ON: begin
            if (!i_in[c]) begin
              if (field_s == CNT_ZERO) begin
                state_s = ST_OFF;
                cnt_s   = CNT_ZERO;
              end else begin
                state_s = ST_FALLING;
                cnt_s   = field_s;
              end
            end else begin
              state_s = ST_ON;
              cnt_s   = cnt_r;
            end
          end
          ST_FALLING: begin
            // The input is only looked at on the expiry tick.
            if (cnt_r == CNT_ONE) begin
              cnt_s = CNT_ZERO;
              if (i_in[c]) begin
                state_s = ST_ON;
              end else begin
                state_s = ST_OFF;
              end
            end else begin
              state_s = ST_FALLING;
              cnt_s   = cnt_r - CNT_ONE;
            end
          end
          default: begin
            state_s = ST_OFF;
            cnt_s   = CNT_ZERO;
          end
        endcase
      end else begin
        state_s = state_r;
        cnt_s   = cnt_r;
      end
    end

    // State, counter and registered outputs for one channel.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        state_r   <= INIT[c] ? ST_ON : ST_OFF;
        cnt_r     <= CNT_ZERO;
        out_r     <= INIT[c];
        pending_r <= 1'b0;
      end else begin
        state_r   <= state_s;
        cnt_r     <= cnt_s;
        out_r     <= (state_s == ST_ON) || (state_s == ST_FALLING);
        pending_r <= (state_s == ST_RISING) || (state_s == ST_FALLING);
      end
    end

    assign o_out[c]     = out_r;
    assign o_pending[c] = pending_r;
  end

endmodule

// File: tb/tb_repeater_bank.sv
// -----------------------------------------------------------------------------
// tb_repeater_bank
//
// Self-checking bench for repeater_bank (CH=4, DW=2, INIT=4'b1010).
// A vector table, directed multi-cycle sequences and a random phase are all
// compared against a tick-counting reference model of the repeater rules.
// -----------------------------------------------------------------------------
module tb_repeater_bank;

  localparam int         CH   = 4;
  localparam int         DW   = 2;
  localparam logic [3:0] INIT = 4'b1010;
`ifdef REPEATER_BANK_PULSE_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] in_v;
  logic [3:0] lock_v;
  logic [7:0] delay_v;
  logic [3:0] out_v;
  logic [3:0] pend_v;

  int checks = 0;
  int errors = 0;

  // Reference model: output value and ticks left until the output flips.
  logic [3:0] m_out;
  int         m_rem [CH];

  always #5 clk = ~clk;

  repeater_bank #(.CH(CH), .DW(DW), .INIT(INIT)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_tick    (tick),
    .i_in      (in_v),
    .i_lock    (lock_v),
    .i_delay   (delay_v),
    .o_out     (out_v),
    .o_pending (pend_v)
  );

  typedef struct {
    logic       rst;
    logic       tick;
    logic [3:0] in;
    logic [3:0] lock;
    logic [3:0] eout;
    logic [3:0] epend;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] model_pend();
    logic [3:0] p;
    for (int c = 0; c < CH; c++) p[c] = (m_rem[c] != 0);
    return p;
  endfunction

  task automatic model_step(input logic r, input logic t, input logic [3:0] in,
                            input logic [3:0] lk, input logic [7:0] dl);
    if (r) begin
      m_out = INIT;
      for (int c = 0; c < CH; c++) m_rem[c] = 0;
    end else if (t) begin
      for (int c = 0; c < CH; c++) begin
        if (!lk[c]) begin
          int d;
          d = int'(dl[c*DW +: DW]) + 1;
          if (m_rem[c] == 0) begin
            if (in[c] != m_out[c]) begin
              if (d == 1) m_out[c] = in[c];
              else        m_rem[c] = d - 1;
            end
          end else if (!m_out[c] && !EXT && !in[c]) begin
            m_rem[c] = 0;
          end else begin
            m_rem[c] = m_rem[c] - 1;
            if (m_rem[c] == 0) m_out[c] = m_out[c] ? in[c] : 1'b1;
          end
        end
      end
    end
  endtask

  // Drive one clock edge, advance the model, sample 1 time unit later and
  // compare against the model.
  task automatic apply(input logic r, input logic t, input logic [3:0] in,
                       input logic [3:0] lk, input logic [7:0] dl);
    rst = r; tick = t; in_v = in; lock_v = lk; delay_v = dl;
    @(posedge clk);
    model_step(r, t, in, lk, dl);
    #1;
    chk("model_out", out_v, m_out);
    chk("model_pend", pend_v, model_pend());
  endtask

  initial begin
    int high_cnt;
    rst = 1'b1; tick = 1'b0; in_v = 4'b0000; lock_v = 4'b0000; delay_v = 8'h00;
    m_out = INIT;
    for (int c = 0; c < CH; c++) m_rem[c] = 0;

    // Delays for the table: ch0 D=3, ch1 D=4, ch2 D=2, ch3 D=3.
    tv[0]  = '{1'b1, 1'b0, 4'b1010, 4'b0000, 4'b1010, 4'b0000};
    tv[1]  = '{1'b0, 1'b1, 4'b1010, 4'b0000, 4'b1010, 4'b0000};
    tv[2]  = '{1'b0, 1'b1, 4'b1011, 4'b0000, 4'b1010, 4'b0001};
    tv[3]  = '{1'b0, 1'b0, 4'b1011, 4'b0000, 4'b1010, 4'b0001};
    tv[4]  = '{1'b0, 1'b1, 4'b1011, 4'b0000, 4'b1010, 4'b0001};
    tv[5]  = '{1'b0, 1'b1, 4'b1011, 4'b0000, 4'b1011, 4'b0000};
    tv[6]  = '{1'b0, 1'b1, 4'b0011, 4'b0000, 4'b1011, 4'b1000};
    tv[7]  = '{1'b0, 1'b1, 4'b1011, 4'b0000, 4'b1011, 4'b1000};
    tv[8]  = '{1'b0, 1'b1, 4'b1011, 4'b0000, 4'b1011, 4'b0000};
    tv[9]  = '{1'b0, 1'b1, 4'b1111, 4'b0100, 4'b1011, 4'b0000};
    tv[10] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1011, 4'b0100};
    tv[11] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1111, 4'b0000};
    tv[12] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b1010, 4'b0000};

    for (int i = 0; i < 13; i++) begin
      apply(tv[i].rst, tv[i].tick, tv[i].in, tv[i].lock, 8'h9E);
      chk($sformatf("table_out[%0d]", i), out_v, tv[i].eout);
      chk($sformatf("table_pend[%0d]", i), pend_v, tv[i].epend);
    end

    // Short pulse on ch1 with D=4: stretched or swallowed.
    apply(1'b0, 1'b1, 4'b1000, 4'b0000, 8'h92);
    chk("pulse_pre_off", out_v, 4'b1000);
    high_cnt = 0;
    apply(1'b0, 1'b1, 4'b1010, 4'b0000, 8'h9E);
    if (out_v[1]) high_cnt++;
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b1, 4'b1000, 4'b0000, 8'h9E);
      if (out_v[1]) high_cnt++;
    end
    chk_int("pulse_high_ticks", high_cnt, EXT ? 4 : 0);

    // Lock ch2 mid-RISING (D=2) for 5 ticks.
    apply(1'b0, 1'b1, 4'b1100, 4'b0000, 8'h9E);
    chk("lock_enter", {out_v[2], pend_v[2], 2'b00}, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, 4'b1100, 4'b0100, 8'h9E);
      chk($sformatf("lock_hold[%0d]", i), {out_v[2], pend_v[2], 2'b00}, 4'b0100);
    end
    apply(1'b0, 1'b1, 4'b1100, 4'b0000, 8'h9E);
    chk("lock_release", {out_v[2], pend_v[2], 2'b00}, 4'b1000);

    // ch3 FALLING (D=3), input returns, delay edited mid-count.
    apply(1'b0, 1'b1, 4'b0100, 4'b0000, 8'h9E);
    chk("fall_enter", {out_v[3], pend_v[3], 2'b00}, 4'b1100);
    apply(1'b0, 1'b1, 4'b1100, 4'b0000, 8'h1E);
    chk("fall_mid", {out_v[3], pend_v[3], 2'b00}, 4'b1100);
    apply(1'b0, 1'b1, 4'b1100, 4'b0000, 8'h1E);
    chk("fall_return_on", {out_v[3], pend_v[3], 2'b00}, 4'b1000);
    apply(1'b0, 1'b1, 4'b0100, 4'b0000, 8'h9E);
    apply(1'b0, 1'b1, 4'b0100, 4'b0000, 8'hDE);
    chk("fall2_mid", {out_v[3], pend_v[3], 2'b00}, 4'b1100);
    apply(1'b0, 1'b1, 4'b0100, 4'b0000, 8'hDE);
    chk("fall2_expire", {out_v[3], pend_v[3], 2'b00}, 4'b0000);

    // All channels RISING, ticks gated, then reset mid-count.
    apply(1'b1, 1'b0, 4'b0000, 4'b0000, 8'h00);
    apply(1'b0, 1'b1, 4'b0000, 4'b0000, 8'h00);
    chk("gate_all_off", out_v, 4'b0000);
    apply(1'b0, 1'b1, 4'b1111, 4'b0000, 8'hFF);
    chk("gate_rising_pend", pend_v, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b0, 4'($urandom), 4'($urandom), 8'($urandom));
      chk($sformatf("gate_out[%0d]", i), out_v, 4'b0000);
      chk($sformatf("gate_pend[%0d]", i), pend_v, 4'b1111);
    end
    apply(1'b0, 1'b1, 4'b1111, 4'b0000, 8'hFF);
    apply(1'b1, 1'b1, 4'b1111, 4'b1111, 8'hFF);
    chk("rst_mid_out", out_v, INIT);
    chk("rst_mid_pend", pend_v, 4'b0000);
    apply(1'b0, 1'b1, 4'b0000, 4'b0000, 8'hFF);
    chk("post_rst_fall", pend_v, 4'b1010);

    // Random phase against the model.
    for (int i = 0; i < 600; i++) begin
      logic r;
      logic t;
      r = ($urandom_range(0, 60) == 0);
      t = ($urandom_range(0, 3) != 0);
      apply(r, t, 4'($urandom), 4'($urandom & $urandom & $urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
